// File: rtl/html_char_reader_pkg.sv
// Shared definitions for the html_char_reader slice.
//   `CHAR_BITES        character width used by every file in the slice
//   CHAR_NUL           document terminator byte
//   CHAR_SPACE/TAB/LF/CR  whitespace bytes
//   fetch_state_t      fetch FSM encoding (FETCH -> DRAIN -> DONE)
//   is_ws_char()       whitespace classifier used by the optional collapse feature
`ifndef CHAR_BITES
`define CHAR_BITES 8
`endif

package html_char_reader_pkg;

  localparam logic [`CHAR_BITES-1:0] CHAR_NUL   = `CHAR_BITES'(8'h00);
  localparam logic [`CHAR_BITES-1:0] CHAR_SPACE = `CHAR_BITES'(8'h20);
  localparam logic [`CHAR_BITES-1:0] CHAR_TAB   = `CHAR_BITES'(8'h09);
  localparam logic [`CHAR_BITES-1:0] CHAR_LF    = `CHAR_BITES'(8'h0A);
  localparam logic [`CHAR_BITES-1:0] CHAR_CR    = `CHAR_BITES'(8'h0D);

  typedef enum logic [1:0] {
    FS_FETCH,
    FS_DRAIN,
    FS_DONE
  } fetch_state_t;

  function automatic logic is_ws_char(input logic [`CHAR_BITES-1:0] c);
    return (c == CHAR_SPACE) || (c == CHAR_TAB) || (c == CHAR_LF) || (c == CHAR_CR);
  endfunction

endpackage

// File: rtl/html_char_reader_fifo.sv
// html_char_fifo: show-ahead prefetch FIFO, DEPTH x WIDTH.
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   push/push_data  write one entry (ignored when full unless popping the same edge)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry, valid whenever !empty
//   empty, count    occupancy status
// DEPTH must be a power of two.
module html_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = `CHAR_BITES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = count[PW];
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = store[rd_ptr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: head is only meaningful while !empty.
  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/html_char_reader.sv
// html_char_reader: memory-backed character source for html_parser.
// Streams a document from a synchronous memory through a prefetch FIFO so the
// parser can pop one character per clock.
//   clock       rising-edge clock
//   reset       asynchronous active-high reset
//   next_char   pop request (honoured only while char_valid)
//   mem_addr    read address to the synchronous memory
//   mem_rd      read strobe; memory samples mem_addr on the next edge
//   mem_data    memory read data, valid the cycle after sampling
//   char        current character (0 when not valid)
//   char_valid  char holds a real document byte
//   eof         sticky end-of-document flag
// Optional build macro HTML_READER_WS_COLLAPSE_EN: maps whitespace to 0x20 and
// drops a whitespace byte that directly follows a pushed whitespace byte.
module html_char_reader
  import html_char_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DOC_LENGTH = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   next_char,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_rd,
  input  logic [`CHAR_BITES-1:0] mem_data,
  output logic [`CHAR_BITES-1:0] char,
  output logic                   char_valid,
  output logic                   eof
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]         DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] DOC_END = (ADDR_WIDTH+1)'(DOC_LENGTH);

  fetch_state_t           state;
  // One extra bit so the counter can rest at DOC_LENGTH == 2**ADDR_WIDTH.
  logic [ADDR_WIDTH:0]    addr_cnt;
  logic                   data_due;   // memory returns data for a tagged read this cycle
  logic                   term_seen;  // NUL marker pushed; later returns are discarded
  logic                   eof_q;

  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic [`CHAR_BITES-1:0] fifo_head;
  logic [`CHAR_BITES-1:0] in_byte;
  logic                   is_nul;
  logic                   drop;
  logic                   push;
  logic                   pop;
  logic                   head_is_marker;
  logic [ADDR_WIDTH:0]    next_addr;
  logic [CW:0]            commit;
  logic                   issue;

`ifdef HTML_READER_WS_COLLAPSE_EN
  logic                   last_ws;
`endif

  assign mem_addr = addr_cnt[ADDR_WIDTH-1:0];

  always_comb begin
    is_nul  = (mem_data == CHAR_NUL);
    in_byte = mem_data;
    drop    = 1'b0;
`ifdef HTML_READER_WS_COLLAPSE_EN
    if (is_ws_char(mem_data)) begin
      in_byte = CHAR_SPACE;
      drop    = last_ws;
    end
`endif
    push = data_due && !term_seen && !drop;

    head_is_marker = !fifo_empty && (fifo_head == CHAR_NUL);
    char_valid     = !fifo_empty && !head_is_marker && !eof_q;
    char           = char_valid ? fifo_head : '0;
    eof            = eof_q || head_is_marker;
    pop            = next_char && char_valid;

    // Slots already committed after this edge: stored + in flight - popped.
    commit = {1'b0, fifo_count} + {{CW{1'b0}}, mem_rd} + {{CW{1'b0}}, data_due}
           - {{CW{1'b0}}, pop};
    // The address being sampled by memory this edge is consumed (post-increment).
    next_addr = addr_cnt + {{ADDR_WIDTH{1'b0}}, mem_rd};
    issue     = (state == FS_FETCH) && !(push && is_nul)
             && (next_addr < DOC_END) && (commit < DEPTH_W);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FS_FETCH;
      addr_cnt  <= '0;
      mem_rd    <= 1'b0;
      data_due  <= 1'b0;
      term_seen <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      mem_rd   <= issue;
      addr_cnt <= next_addr;
      data_due <= mem_rd;
      if (push && is_nul) term_seen <= 1'b1;
      case (state)
        FS_FETCH: begin
          if ((push && is_nul) || (next_addr >= DOC_END)) state <= FS_DRAIN;
        end
        FS_DRAIN: begin
          if (fifo_empty && !mem_rd && !data_due) begin
            state <= FS_DONE;
            if (!term_seen) eof_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HTML_READER_WS_COLLAPSE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_ws <= 1'b0;
    end else if (push) begin
      last_ws <= is_ws_char(mem_data);
    end
  end
`endif

  html_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (`CHAR_BITES)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (in_byte),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_html_char_reader.sv
module tb_html_char_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       main_next = 1'b0;
  logic [3:0] main_addr;
  logic       main_rd;
  logic [7:0] main_data = 8'h00;
  logic [7:0] main_char;
  logic       main_valid;
  logic       main_eof;

  logic       len_next = 1'b0;
  logic [3:0] len_addr;
  logic       len_rd;
  logic [7:0] len_data = 8'h00;
  logic [7:0] len_char;
  logic       len_valid;
  logic       len_eof;

  logic [7:0] rom_main [16];
  logic [7:0] rom_len  [16];

  int checks = 0;
  int failures = 0;
  int len_bad_rd = 0;
  int len_addr_over = 0;

  always #5 clock = ~clock;

  html_char_reader #(.ADDR_WIDTH(4), .DOC_LENGTH(16), .FIFO_DEPTH(4)) u_main (
    .clock(clock), .reset(reset), .next_char(main_next), .mem_addr(main_addr),
    .mem_rd(main_rd), .mem_data(main_data), .char(main_char),
    .char_valid(main_valid), .eof(main_eof)
  );

  html_char_reader #(.ADDR_WIDTH(4), .DOC_LENGTH(3), .FIFO_DEPTH(4)) u_len (
    .clock(clock), .reset(reset), .next_char(len_next), .mem_addr(len_addr),
    .mem_rd(len_rd), .mem_data(len_data), .char(len_char),
    .char_valid(len_valid), .eof(len_eof)
  );

  // Synchronous memories: sample address on the edge, data valid afterwards.
  always @(posedge clock) begin
    if (main_rd) main_data <= rom_main[main_addr];
    if (len_rd)  len_data  <= rom_len[len_addr];
  end

  always @(negedge clock) begin
    if (len_rd && len_addr > 4'd2) len_bad_rd++;
    if (len_addr > 4'd3) len_addr_over++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    main_next = 1'b0;
    len_next = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic load_terminated();
    for (int i = 0; i < 16; i++) rom_main[i] = 8'h5A;
    rom_main[0] = 8'h61; rom_main[1] = 8'h62; rom_main[2] = 8'h3C; rom_main[3] = 8'h00;
  endtask

  task automatic load_letters(input logic [7:0] base);
    for (int i = 0; i < 16; i++) rom_main[i] = 8'(base + 8'(i));
  endtask

  task automatic test_reset();
    load_terminated();
    reset = 1'b1;
    #1;
    checks++; if (main_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", main_addr); end
    checks++; if (main_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%0b exp=0", main_rd); end
    checks++; if (main_char !== 8'h00) begin failures++; $display("FAIL reset_char got=%0h exp=0", main_char); end
    checks++; if (main_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", main_valid); end
    checks++; if (main_eof !== 1'b0) begin failures++; $display("FAIL reset_eof got=%0b exp=0", main_eof); end
  endtask

  task automatic test_terminator();
    load_terminated();
    do_reset();
    tick(); tick();
    checks++; if (main_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%0b exp=0", main_valid); end
    tick();
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h61) begin failures++; $display("FAIL first_char got=%0b/%0h exp=1/61", main_valid, main_char); end
    main_next = 1'b1;
    tick();
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h62) begin failures++; $display("FAIL term_b got=%0b/%0h exp=1/62", main_valid, main_char); end
    tick();
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h3C) begin failures++; $display("FAIL term_lt got=%0b/%0h exp=1/3c", main_valid, main_char); end
    tick();
    checks++; if (main_eof !== 1'b1 || main_valid !== 1'b0 || main_char !== 8'h00) begin failures++; $display("FAIL term_eof got=%0b/%0b/%0h exp=1/0/0", main_eof, main_valid, main_char); end
    main_next = 1'b0;
    repeat (4) tick();
    checks++; if (main_eof !== 1'b1 || main_valid !== 1'b0 || main_rd !== 1'b0) begin failures++; $display("FAIL term_hold got=%0b/%0b/%0b exp=1/0/0", main_eof, main_valid, main_rd); end
  endtask

  task automatic test_length_end();
    rom_len[0] = 8'h78; rom_len[1] = 8'h79; rom_len[2] = 8'h7A; rom_len[3] = 8'h77;
    do_reset();
    repeat (3) tick();
    checks++; if (len_valid !== 1'b1 || len_char !== 8'h78) begin failures++; $display("FAIL len_x got=%0b/%0h exp=1/78", len_valid, len_char); end
    len_next = 1'b1;
    tick();
    checks++; if (len_valid !== 1'b1 || len_char !== 8'h79) begin failures++; $display("FAIL len_y got=%0b/%0h exp=1/79", len_valid, len_char); end
    tick();
    checks++; if (len_valid !== 1'b1 || len_char !== 8'h7A) begin failures++; $display("FAIL len_z got=%0b/%0h exp=1/7a", len_valid, len_char); end
    tick();
    checks++; if (len_valid !== 1'b0 || len_eof !== 1'b0) begin failures++; $display("FAIL len_eof_early got=%0b/%0b exp=0/0", len_valid, len_eof); end
    len_next = 1'b0;
    tick();
    checks++; if (len_eof !== 1'b1 || len_char !== 8'h00) begin failures++; $display("FAIL len_eof got=%0b/%0h exp=1/0", len_eof, len_char); end
    repeat (3) tick();
    checks++; if (len_eof !== 1'b1 || len_addr !== 4'd3) begin failures++; $display("FAIL len_sat got=%0b/%0h exp=1/3", len_eof, len_addr); end
    checks++; if (len_bad_rd !== 0 || len_addr_over !== 0) begin failures++; $display("FAIL len_bounds got=%0d/%0d exp=0/0", len_bad_rd, len_addr_over); end
  endtask

  task automatic test_backpressure();
    int rd_cnt;
    rd_cnt = 0;
    load_letters(8'h61);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (main_rd) rd_cnt++;
    end
    checks++; if (rd_cnt !== 4) begin failures++; $display("FAIL hold_issues got=%0d exp=4", rd_cnt); end
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h61) begin failures++; $display("FAIL hold_head got=%0b/%0h exp=1/61", main_valid, main_char); end
    checks++; if (main_addr !== 4'd4) begin failures++; $display("FAIL hold_addr got=%0h exp=4", main_addr); end
  endtask

  task automatic test_sustained();
    logic [7:0] exp_c;
    main_next = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_c = 8'(8'h61 + 8'(i));
      checks++; if (main_valid !== 1'b1 || main_char !== exp_c) begin failures++; $display("FAIL stream_%0d got=%0b/%0h exp=1/%0h", i, main_valid, main_char, exp_c); end
    end
    tick();
    checks++; if (main_valid !== 1'b0 || main_eof !== 1'b0) begin failures++; $display("FAIL stream_empty got=%0b/%0b exp=0/0", main_valid, main_eof); end
    main_next = 1'b0;
    tick();
    checks++; if (main_eof !== 1'b1) begin failures++; $display("FAIL stream_eof got=%0b exp=1", main_eof); end
  endtask

  task automatic test_reset_midstream();
    load_letters(8'h61);
    do_reset();
    repeat (3) tick();
    main_next = 1'b1;
    tick(); tick();
    checks++; if (main_char !== 8'h63 || main_rd !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0h/%0b exp=63/1", main_char, main_rd); end
    reset = 1'b1;
    #1;
    checks++; if (main_addr !== 4'd0 || main_rd !== 1'b0 || main_char !== 8'h00 || main_valid !== 1'b0 || main_eof !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0h/%0b/%0h/%0b/%0b exp=0/0/0/0/0", main_addr, main_rd, main_char, main_valid, main_eof);
    end
    main_next = 1'b0;
    load_letters(8'h41);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h41) begin failures++; $display("FAIL mid_restart got=%0b/%0h exp=1/41", main_valid, main_char); end
    main_next = 1'b1;
    tick();
    checks++; if (main_char !== 8'h42) begin failures++; $display("FAIL mid_second got=%0h exp=42", main_char); end
    tick();
    checks++; if (main_char !== 8'h43) begin failures++; $display("FAIL mid_third got=%0h exp=43", main_char); end
    main_next = 1'b0;
  endtask

  task automatic test_whitespace();
    logic [7:0] ws_exp [5];
    int ws_n;
    int idx;
    int guard;
`ifdef HTML_READER_WS_COLLAPSE_EN
    ws_n = 3;
    ws_exp[0] = 8'h61; ws_exp[1] = 8'h20; ws_exp[2] = 8'h62; ws_exp[3] = 8'h00; ws_exp[4] = 8'h00;
`else
    ws_n = 5;
    ws_exp[0] = 8'h61; ws_exp[1] = 8'h20; ws_exp[2] = 8'h09; ws_exp[3] = 8'h0A; ws_exp[4] = 8'h62;
`endif
    for (int i = 0; i < 16; i++) rom_main[i] = 8'h7E;
    rom_main[0] = 8'h61; rom_main[1] = 8'h20; rom_main[2] = 8'h09;
    rom_main[3] = 8'h0A; rom_main[4] = 8'h62; rom_main[5] = 8'h00;
    do_reset();
    idx = 0;
    guard = 0;
    while (idx < ws_n && guard < 40) begin
      if (main_valid) begin
        checks++; if (main_char !== ws_exp[idx]) begin failures++; $display("FAIL ws_char_%0d got=%0h exp=%0h", idx, main_char, ws_exp[idx]); end
        idx++;
        main_next = 1'b1;
      end else begin
        main_next = 1'b0;
      end
      tick();
      guard++;
    end
    main_next = 1'b0;
    checks++; if (idx !== ws_n) begin failures++; $display("FAIL ws_timeout got=%0d exp=%0d", idx, ws_n); end
    guard = 0;
    while (!main_eof && guard < 10) begin
      tick();
      guard++;
    end
    checks++; if (main_eof !== 1'b1 || main_valid !== 1'b0 || main_char !== 8'h00) begin failures++; $display("FAIL ws_eof got=%0b/%0b/%0h exp=1/0/0", main_eof, main_valid, main_char); end
  endtask

  task automatic test_ignored_requests();
    load_terminated();
    do_reset();
    main_next = 1'b1;
    tick(); tick();
    checks++; if (main_valid !== 1'b0) begin failures++; $display("FAIL ign_pre_valid got=%0b exp=0", main_valid); end
    tick();
    checks++; if (main_valid !== 1'b1 || main_char !== 8'h61 || main_addr !== 4'd2) begin failures++; $display("FAIL ign_first got=%0b/%0h/%0h exp=1/61/2", main_valid, main_char, main_addr); end
    tick(); tick(); tick();
    checks++; if (main_eof !== 1'b1 || main_addr !== 4'd5) begin failures++; $display("FAIL ign_eof got=%0b/%0h exp=1/5", main_eof, main_addr); end
    repeat (3) tick();
    checks++; if (main_eof !== 1'b1 || main_valid !== 1'b0 || main_char !== 8'h00 || main_addr !== 4'd5 || main_rd !== 1'b0) begin
      failures++; $display("FAIL ign_after_eof got=%0b/%0b/%0h/%0h/%0b exp=1/0/0/5/0", main_eof, main_valid, main_char, main_addr, main_rd);
    end
    main_next = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_len[i] = 8'h77;
    test_reset();
    test_terminator();
    test_length_end();
    test_backpressure();
    test_sustained();
    test_reset_midstream();
    test_whitespace();
    test_ignored_requests();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
